test_sync_mem_pipe: RTL

- Parametrised single-port synchronous test memory with valid/ready request and response channels.
- Supports configurable read latency, byte-masked writes and a bounded response buffer with back-pressure.
- Sits behind testbench drivers and DPI shims as the next-generation backing store for co-simulation devices.
- Contents stay directly accessible by hierarchical reference (array name mem) for DPI preload and dump.

---
 rtl/test_sync_mem_pipe_if.sv | 27 ++
 rtl/test_sync_mem_pipe.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/test_sync_mem_pipe_if.sv
// Request/response handshake bundle for test_sync_mem_pipe.
// The master drives requests and consumes responses; the slave is the memory.
interface test_sync_mem_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                    req_v;
  logic                    req_ready;
  logic                    req_we;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_data;
  logic [DATA_WIDTH/8-1:0] req_mask;
  logic                    resp_v;
  logic                    resp_ready;
  logic                    resp_we;
  logic [DATA_WIDTH-1:0]   resp_data;

  modport master (
    output req_v, req_we, req_addr, req_data, req_mask, resp_ready,
    input  req_ready, resp_v, resp_we, resp_data
  );

  modport slave (
    input  req_v, req_we, req_addr, req_data, req_mask, resp_ready,
    output req_ready, resp_v, resp_we, resp_data
  );
endinterface

// File: rtl/test_sync_mem_pipe.sv
// Single-port test memory: fixed-latency read pipe feeding a credit-managed response FIFO.
// Optional saturating stat counters are enabled by defining TEST_SYNC_MEM_PIPE_STATS_EN.
module test_sync_mem_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 1,
  parameter int RESP_DEPTH = 2
) (
  input  logic clk,
  input  logic reset_n,
  test_sync_mem_pipe_if.slave bus
`ifdef TEST_SYNC_MEM_PIPE_STATS_EN
  ,
  output logic [31:0] stat_reads,
  output logic [31:0] stat_writes,
  output logic [31:0] stat_stall
`endif
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = $clog2(RESP_DEPTH + 1);
  localparam int PW    = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

  // Left un-reset so contents survive reset and stay reachable for preload/dump.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  accept, pop;
  logic [DATA_WIDTH-1:0] rd_dat;
  logic                  push_vld, push_we;
  logic [DATA_WIDTH-1:0] push_dat;

  logic [CW-1:0] cnt_q, cnt_d, occ_q, occ_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [RESP_DEPTH-1:0]                 fifo_we_q, fifo_we_d;
  logic [RESP_DEPTH-1:0][DATA_WIDTH-1:0] fifo_dat_q, fifo_dat_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credits cover both in-flight and buffered entries, so the FIFO cannot overflow.
  assign bus.req_ready = (cnt_q < CW'(RESP_DEPTH));
  assign bus.resp_v    = (occ_q != '0);
  assign bus.resp_we   = bus.resp_v & fifo_we_q[rd_ptr_q];
  assign bus.resp_data = bus.resp_v ? fifo_dat_q[rd_ptr_q] : '0;

  assign accept = bus.req_v & bus.req_ready;
  assign pop    = bus.resp_v & bus.resp_ready;
  assign rd_dat = (accept && !bus.req_we) ? mem[bus.req_addr] : '0;

  always_ff @(posedge clk) begin
    if (accept && bus.req_we) begin
      for (int i = 0; i < NB; i++)
        if (bus.req_mask[i]) mem[bus.req_addr][8*i +: 8] <= bus.req_data[8*i +: 8];
    end
  end

  // The acceptance edge is the first of LATENCY stages; LATENCY==1 writes the FIFO directly.
  generate
    if (LATENCY == 1) begin : g_direct
      assign push_vld = accept;
      assign push_we  = accept & bus.req_we;
      assign push_dat = rd_dat;
    end else begin : g_pipe
      logic [LATENCY-1:1]                 vld_pipe_q, vld_pipe_d, we_pipe_q, we_pipe_d;
      logic [LATENCY-1:1][DATA_WIDTH-1:0] dat_pipe_q, dat_pipe_d;

      always_comb begin
        vld_pipe_d    = vld_pipe_q;
        we_pipe_d     = we_pipe_q;
        dat_pipe_d    = dat_pipe_q;
        vld_pipe_d[1] = accept;
        we_pipe_d[1]  = accept & bus.req_we;
        dat_pipe_d[1] = rd_dat;
        for (int i = 2; i < LATENCY; i++) begin
          vld_pipe_d[i] = vld_pipe_q[i-1];
          we_pipe_d[i]  = we_pipe_q[i-1];
          dat_pipe_d[i] = dat_pipe_q[i-1];
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          vld_pipe_q <= '0;
          we_pipe_q  <= '0;
          dat_pipe_q <= '0;
        end else begin
          vld_pipe_q <= vld_pipe_d;
          we_pipe_q  <= we_pipe_d;
          dat_pipe_q <= dat_pipe_d;
        end
      end

      assign push_vld = vld_pipe_q[LATENCY-1];
      assign push_we  = we_pipe_q[LATENCY-1];
      assign push_dat = dat_pipe_q[LATENCY-1];
    end
  endgenerate

  always_comb begin
    cnt_d      = cnt_q;
    occ_d      = occ_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_we_d  = fifo_we_q;
    fifo_dat_d = fifo_dat_q;
    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: ;
    endcase
    case ({push_vld, pop})
      2'b10:   occ_d = occ_q + CW'(1);
      2'b01:   occ_d = occ_q - CW'(1);
      default: ;
    endcase
    if (push_vld) begin
      fifo_we_d[wr_ptr_q]  = push_we;
      fifo_dat_d[wr_ptr_q] = push_dat;
      wr_ptr_d             = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      occ_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_we_q  <= '0;
      fifo_dat_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      occ_q      <= occ_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_we_q  <= fifo_we_d;
      fifo_dat_q <= fifo_dat_d;
    end
  end

`ifdef TEST_SYNC_MEM_PIPE_STATS_EN
  logic [31:0] st_rd_q, st_rd_d, st_wr_q, st_wr_d, st_stall_q, st_stall_d;

  always_comb begin
    st_rd_d    = st_rd_q;
    st_wr_d    = st_wr_q;
    st_stall_d = st_stall_q;
    if (accept && !bus.req_we && st_rd_q != '1) st_rd_d = st_rd_q + 32'd1;
    if (accept && bus.req_we && st_wr_q != '1)  st_wr_d = st_wr_q + 32'd1;
    if (bus.resp_v && !bus.resp_ready && st_stall_q != '1) st_stall_d = st_stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_rd_q    <= '0;
      st_wr_q    <= '0;
      st_stall_q <= '0;
    end else begin
      st_rd_q    <= st_rd_d;
      st_wr_q    <= st_wr_d;
      st_stall_q <= st_stall_d;
    end
  end

  assign stat_reads  = st_rd_q;
  assign stat_writes = st_wr_q;
  assign stat_stall  = st_stall_q;
`endif
endmodule
